// File: rtl/sparse_mac_pe.sv
// Sparse MAC processing element: intersects a compressed IA fibre with a compressed
// weight fibre by channel index and accumulates matching products into N_OUT sums.
//
// state | meaning
// IDLE  | buffers writable, waiting for i_start
// MERGE | two-pointer compare, one step per cycle; matches feed stage 2
// FLUSH | one cycle for the last stage-2 write to retire
// DRAIN | stream acc[0..N_OUT-1] over valid/ready
module sparse_mac_pe #(
  parameter int DATA_W  = 16,
  parameter int CIDX_W  = 5,
  parameter int N_OUT   = 16,
  parameter int ACC_W   = 40,
  parameter int MAX_LEN = 64,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int ADDR_W = $clog2(MAX_LEN),
  localparam int KIDX_W = $clog2(N_OUT)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ia_wr_en,
  input  logic [ADDR_W-1:0]        i_ia_wr_addr,
  input  logic signed [DATA_W-1:0] i_ia_wr_data,
  input  logic [CIDX_W-1:0]        i_ia_wr_cidx,
  input  logic                     i_w_wr_en,
  input  logic [ADDR_W-1:0]        i_w_wr_addr,
  input  logic signed [DATA_W-1:0] i_w_wr_data,
  input  logic [CIDX_W-1:0]        i_w_wr_cidx,
  input  logic [KIDX_W-1:0]        i_w_wr_kidx,
  input  logic [LEN_W-1:0]         i_ia_len,
  input  logic [LEN_W-1:0]         i_w_len,
  input  logic                     i_acc_clear,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_out_valid,
  output logic [ACC_W-1:0]         o_out_data,
  output logic [KIDX_W-1:0]        o_out_idx,
  input  logic                     i_out_ready,
  output logic                     o_finish,
  output logic [LEN_W:0]           o_mac_count
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [ADDR_W:0]   MAX_ADDR = (ADDR_W + 1)'(MAX_LEN);
  localparam logic [LEN_W-1:0]  MAX_L    = LEN_W'(MAX_LEN);
  localparam logic [KIDX_W-1:0] LAST_K   = KIDX_W'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MERGE, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;

  logic signed [DATA_W-1:0] ia_d [MAX_LEN];
  logic [CIDX_W-1:0]        ia_c [MAX_LEN];
  logic signed [DATA_W-1:0] w_d  [MAX_LEN];
  logic [CIDX_W-1:0]        w_c  [MAX_LEN];
  logic [KIDX_W-1:0]        w_k  [MAX_LEN];
  logic signed [ACC_W-1:0]  acc  [N_OUT];

  logic [LEN_W-1:0]         ia_len_q, w_len_q, i_q, j_q;
  logic [LEN_W:0]           mac_q;
  logic                     s2_valid_q, finish_q;
  logic signed [PROD_W-1:0] prod_q;
  logic [KIDX_W-1:0]        k_q, idx_q;

  logic                     merge_done, start_ok;
  logic [CIDX_W-1:0]        ia_c_cur, w_c_cur;
  logic signed [DATA_W-1:0] ia_d_cur, w_d_cur;
  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W-1:0]  sum_sat;

  assign start_ok   = (state_q == IDLE) && i_start;
  assign merge_done = (i_q >= ia_len_q) || (j_q >= w_len_q);
  assign ia_c_cur   = ia_c[i_q[ADDR_W-1:0]];
  assign ia_d_cur   = ia_d[i_q[ADDR_W-1:0]];
  assign w_c_cur    = w_c[j_q[ADDR_W-1:0]];
  assign w_d_cur    = w_d[j_q[ADDR_W-1:0]];

  // Buffers are plain registers; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && i_ia_wr_en && ({1'b0, i_ia_wr_addr} < MAX_ADDR)) begin
      ia_d[i_ia_wr_addr] <= i_ia_wr_data;
      ia_c[i_ia_wr_addr] <= i_ia_wr_cidx;
    end
    if (state_q == IDLE && i_w_wr_en && ({1'b0, i_w_wr_addr} < MAX_ADDR)) begin
      w_d[i_w_wr_addr] <= i_w_wr_data;
      w_c[i_w_wr_addr] <= i_w_wr_cidx;
      w_k[i_w_wr_addr] <= i_w_wr_kidx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = MERGE;
      MERGE:   if (merge_done) state_d = FLUSH;
      FLUSH:   state_d = DRAIN;
      DRAIN:   if (i_out_ready && idx_q == LAST_K) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ia_len_q   <= '0;
      w_len_q    <= '0;
      i_q        <= '0;
      j_q        <= '0;
      mac_q      <= '0;
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
      k_q        <= '0;
      idx_q      <= '0;
      finish_q   <= 1'b0;
    end else begin
      finish_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          ia_len_q <= (i_ia_len > MAX_L) ? MAX_L : i_ia_len;
          w_len_q  <= (i_w_len > MAX_L) ? MAX_L : i_w_len;
          i_q      <= '0;
          j_q      <= '0;
          mac_q    <= '0;
        end
        MERGE: if (!merge_done) begin
          if (ia_c_cur < w_c_cur) begin
            i_q <= i_q + 1'b1;
          end else if (ia_c_cur > w_c_cur) begin
            j_q <= j_q + 1'b1;
          end else begin
            // IA stays put on a match so later weights on the same channel still hit it.
            prod_q     <= PROD_W'(ia_d_cur) * PROD_W'(w_d_cur);
            k_q        <= w_k[j_q[ADDR_W-1:0]];
            s2_valid_q <= 1'b1;
            j_q        <= j_q + 1'b1;
            mac_q      <= mac_q + 1'b1;
          end
        end
        FLUSH: idx_q <= '0;
        DRAIN: if (i_out_ready) begin
          if (idx_q == LAST_K) finish_q <= 1'b1;
          else                 idx_q    <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One guard bit is enough to detect overflow of a single add.
  always_comb begin
    sum     = {acc[k_q][ACC_W-1], acc[k_q]}
            + {{(ACC_W + 1 - PROD_W){prod_q[PROD_W-1]}}, prod_q};
    sum_sat = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
    end else if (start_ok && i_acc_clear) begin
      for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
    end else if (s2_valid_q) begin
      acc[k_q] <= sum_sat;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_out_valid = (state_q == DRAIN);
  assign o_out_data  = (state_q == DRAIN) ? acc[idx_q] : '0;
  assign o_out_idx   = (state_q == DRAIN) ? idx_q : '0;
  assign o_finish    = finish_q;
  assign o_mac_count = mac_q;

endmodule

// File: doc/sparse_mac_pe.md
# sparse_mac_pe

Parametrised sparse processing element for the object-tracking CNN accelerator. It holds one compressed input-activation (IA) fibre and one compressed weight fibre, intersects them by channel index with a two-pointer merge, and multiply-accumulates matches into N_OUT output-channel accumulators. It then drains the accumulators over a valid/ready stream. Optional accumulate mode keeps partial sums across tiles.

## Interface
- DATA_W, 16: signed IA/weight value width
- CIDX_W, 5: channel index width
- N_OUT, 16: number of output accumulators (kernel index range)
- ACC_W, 40: signed accumulator width, must be ≥ 2*DATA_W
- MAX_LEN, 64: depth of each fibre buffer; LEN_W = clog2(MAX_LEN+1), ADDR_W = clog2(MAX_LEN), KIDX_W = clog2(N_OUT)

- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low; clock i_clk
- i_ia_wr_en / i_ia_wr_addr / i_ia_wr_data / i_ia_wr_cidx  in  1/ADDR_W/DATA_W/CIDX_W  IA buffer write port
- i_w_wr_en / i_w_wr_addr / i_w_wr_data / i_w_wr_cidx / i_w_wr_kidx  in  1/ADDR_W/DATA_W/CIDX_W/KIDX_W  weight buffer write port
- i_ia_len, i_w_len  in  LEN_W  valid entries per fibre, sampled on start
- i_acc_clear  in  1  sampled on start; 1 = zero accumulators before merge
- i_start  in  1  start pulse, honoured only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_out_valid  out  1  drain entry valid
- o_out_data  out  ACC_W  accumulator value
- o_out_idx  out  KIDX_W  accumulator index
- i_out_ready  in  1  downstream accept
- o_finish  out  1  one-cycle pulse after the last entry is accepted
- o_mac_count  out  LEN_W+1  number of matches in the last run

## Operation
- Buffers are register arrays with combinational read. Writes are accepted only in IDLE and ignored otherwise. Addresses ≥ MAX_LEN are ignored.
- Channel order contract:
  - IA cidx values are strictly ascending and unique.
  - W cidx values are non-decreasing; several weights may share a channel, each with its own kidx.
- States: IDLE → MERGE → FLUSH → DRAIN → IDLE.
- IDLE, i_start=1:
  - latch lengths, clamped to MAX_LEN
  - clear i, j and the match counter
  - if i_acc_clear, zero all accumulators
  - enter MERGE
- MERGE, one compare per cycle, stage 1:
  - If i ≥ ia_len or j ≥ w_len, go to FLUSH.
  - If ia_c[i] < w_c[j], i++.
  - If ia_c[i] > w_c[j], j++.
  - If equal: register product = ia_d[i]*w_d[j] (signed, 2*DATA_W) and k = w_k[j]; set stage-2 valid; j++; match count +1.
- Stage 2, one cycle after a match: acc[k] ← sat(acc[k] + sign-extended product).
  - sat clips to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)).
  - Only one stage-2 write per cycle, so there is no same-index hazard.
- FLUSH lasts one cycle and lets stage 2 retire. Then enter DRAIN with idx = 0.
- DRAIN:
  - o_out_valid=1, o_out_idx=idx, o_out_data=acc[idx]
  - idx advances on valid&&ready
  - after idx N_OUT-1 is accepted, pulse o_finish and go to IDLE
- i_start outside IDLE is ignored.
- With accumulate mode (i_acc_clear=0), accumulators persist from the previous run.

## Timing
- Reset values:
  - state IDLE; o_busy, o_out_valid, o_finish = 0
  - o_out_data, o_out_idx, o_mac_count = 0
  - all accumulators = 0; buffer contents undefined
- Reset mid-operation aborts immediately to IDLE with the values above.
- i_start in cycle T gives o_busy=1 from T+1.
- MERGE takes at most ia_len + w_len cycles plus one exit cycle. If either length is 0, MERGE takes exactly 1 cycle.
- FLUSH is 1 cycle.
- DRAIN takes at least N_OUT cycles; one entry per cycle with ready held high.
- While o_out_valid && !i_out_ready, o_out_data and o_out_idx are held stable.
- o_finish is asserted in the cycle after the final handshake, coincident with o_busy=0.
- o_mac_count updates live during MERGE and holds until the next start.

## Test plan
- Basic match:
  - IA {(c1,3),(c4,-2)}; W {(c1,5,k2),(c4,7,k2),(c9,1,k0)}; clear=1
  - expect acc[2] = 15 - 14 = 1, all others 0
  - o_mac_count=2; MERGE ≤ 6 cycles; 16 drain entries in order, then o_finish
- Shared channel:
  - IA {(c3,4)}; W {(c3,2,k0),(c3,-3,k5),(c3,1,k0)}
  - expect acc[0]=12, acc[5]=-12, o_mac_count=3
- Accumulate mode: run the basic case twice, the second with i_acc_clear=0. Expect acc[2]=2.
- Saturation:
  - ACC_W=32, clear=1, 64 matches of 32767*32767 into k1
  - expect acc[1] = 2147483647; negative mirror gives -2147483648
- Backpressure and zero length:
  - ia_len=0; i_out_ready toggles 1,0,0,1…
  - expect MERGE 1 cycle, outputs stable while stalled, 16 entries, single o_finish pulse
- Reset and ignore:
  - assert i_rst_n=0 during DRAIN at idx 7; expect all outputs 0, IDLE, accumulators 0
  - i_start and buffer writes while busy have no effect
